// File: rtl/imem_uart_loader_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// imem_uart_loader_pkg : shared widths, UART default and loader state codes
// Rev 1.0
// ---------------------------------------------------------------------------
package imem_uart_loader_pkg;

   localparam int ISA_WIDTH         = 32;
   localparam int UART_BAUD_DEFAULT = 115_200;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_ARMED = 3'd1;
   localparam logic [2:0] ST_LOAD  = 3'd2;
   localparam logic [2:0] ST_FLUSH = 3'd3;
   localparam logic [2:0] ST_DONE  = 3'd4;

   localparam logic [1:0] RX_IDLE  = 2'd0;
   localparam logic [1:0] RX_START = 2'd1;
   localparam logic [1:0] RX_DATA  = 2'd2;
   localparam logic [1:0] RX_STOP  = 2'd3;

   function automatic int baud_div(input int clk_hz, input int baud);
      return clk_hz / baud;
   endfunction

endpackage
`default_nettype wire

// File: rtl/imem_uart_loader_uart_rx_byte.sv
`default_nettype none
// ---------------------------------------------------------------------------
// imem_uart_loader_uart_rx_byte : 8N1 receiver with input synchroniser
// Rev 1.0
// ---------------------------------------------------------------------------
module imem_uart_loader_uart_rx_byte
   import imem_uart_loader_pkg::*;
#(
   parameter int CLK_FREQ_HZ = 23_000_000,
   parameter int BAUD        = UART_BAUD_DEFAULT
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       rx_i,
   output logic [7:0] data_o,
   output logic       valid_o,
   output logic       frame_err_o,
   output logic       busy_o
);

   localparam int DIV = baud_div(CLK_FREQ_HZ, BAUD);
   localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] CNT_FULL = CW'(DIV - 1);
   localparam logic [CW-1:0] CNT_HALF = CW'(DIV / 2 - 1);

   logic          sync1_q, sync2_q, prev_q;
   logic [1:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    shift_q, shift_d;
   logic [7:0]    data_q, data_d;
   logic          valid_q, valid_d;
   logic          ferr_q, ferr_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + 1'b1;
      bit_d   = bit_q;
      shift_d = shift_q;
      data_d  = data_q;
      valid_d = 1'b0;
      ferr_d  = 1'b0;
      case (state_q)
         RX_IDLE: begin
            cnt_d = '0;
            if (prev_q && !sync2_q) state_d = RX_START;
         end
         // A start that is high again at half a bit is treated as noise.
         RX_START: if (cnt_q == CNT_HALF) begin
            cnt_d   = '0;
            bit_d   = 3'd0;
            state_d = sync2_q ? RX_IDLE : RX_DATA;
         end
         RX_DATA: if (cnt_q == CNT_FULL) begin
            cnt_d   = '0;
            shift_d = {sync2_q, shift_q[7:1]};
            bit_d   = bit_q + 3'd1;
            if (bit_q == 3'd7) state_d = RX_STOP;
         end
         RX_STOP: if (cnt_q == CNT_FULL) begin
            cnt_d   = '0;
            state_d = RX_IDLE;
            if (sync2_q) begin
               valid_d = 1'b1;
               data_d  = shift_q;
            end else begin
               ferr_d  = 1'b1;
            end
         end
         default: state_d = RX_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         prev_q  <= 1'b1;
         state_q <= RX_IDLE;
         cnt_q   <= '0;
         bit_q   <= 3'd0;
         shift_q <= 8'd0;
         data_q  <= 8'd0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         sync1_q <= rx_i;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         ferr_q  <= ferr_d;
      end
   end

   assign data_o      = data_q;
   assign valid_o     = valid_q;
   assign frame_err_o = ferr_q;
   assign busy_o      = (state_q != RX_IDLE);

endmodule
`default_nettype wire

// File: rtl/imem_uart_loader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// imem_uart_loader : UART program-image loader into instruction memory
// Rev 1.0
// ---------------------------------------------------------------------------
module imem_uart_loader
   import imem_uart_loader_pkg::*;
#(
   parameter int CLK_FREQ_HZ = 23_000_000,
   parameter int BAUD        = UART_BAUD_DEFAULT,
   parameter int IDLE_BITS   = 32,
   parameter int AW          = 14
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 uart_rx_i,
   input  logic                 start_load_i,
   output logic                 imem_we_o,
   output logic [AW-1:0]        imem_addr_o,
   output logic [ISA_WIDTH-1:0] imem_wdata_o,
   output logic                 cpu_hold_o,
   output logic                 load_done_o,
   output logic                 frame_err_o
);

   localparam int IDLE_CYCLES = IDLE_BITS * baud_div(CLK_FREQ_HZ, BAUD);
   localparam int TW          = $clog2(IDLE_CYCLES + 1);
   localparam logic [TW-1:0] IDLE_LAST = TW'(IDLE_CYCLES - 1);
   localparam logic [AW-1:0] ADDR_LAST = '1;

   logic [7:0] rx_data;
   logic       rx_valid, rx_ferr, rx_busy;

   logic [2:0]           state_q, state_d;
   logic                 start_q;
   logic [AW-1:0]        word_cnt_q, word_cnt_d;
   logic [1:0]           byte_idx_q, byte_idx_d;
   logic [23:0]          pack_q, pack_d;
   logic [TW-1:0]        timer_q, timer_d;
   logic                 we_q, we_d;
   logic [AW-1:0]        addr_q, addr_d;
   logic [ISA_WIDTH-1:0] wdata_q, wdata_d;
   logic                 ferr_q, ferr_d;
   logic                 start_edge;

   imem_uart_loader_uart_rx_byte #(
      .CLK_FREQ_HZ (CLK_FREQ_HZ),
      .BAUD        (BAUD)
   ) u_rx (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .rx_i        (uart_rx_i),
      .data_o      (rx_data),
      .valid_o     (rx_valid),
      .frame_err_o (rx_ferr),
      .busy_o      (rx_busy)
   );

   assign start_edge = start_load_i & ~start_q;

   always_comb begin
      state_d    = state_q;
      word_cnt_d = word_cnt_q;
      byte_idx_d = byte_idx_q;
      pack_d     = pack_q;
      timer_d    = timer_q;
      we_d       = 1'b0;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      ferr_d     = ferr_q;
      case (state_q)
         ST_IDLE, ST_DONE: if (start_edge) begin
            state_d    = ST_ARMED;
            word_cnt_d = '0;
            byte_idx_d = 2'd0;
            pack_d     = '0;
            timer_d    = '0;
            ferr_d     = 1'b0;
         end
         ST_ARMED, ST_LOAD: begin
            if (rx_ferr) ferr_d = 1'b1;
            // Silence is only counted while no frame is in flight.
            if (rx_valid || rx_busy) begin
               timer_d = '0;
            end else if (state_q == ST_LOAD) begin
               if (timer_q == IDLE_LAST) state_d = ST_FLUSH;
               else                      timer_d = timer_q + 1'b1;
            end
            if (rx_valid) begin
               state_d    = ST_LOAD;
               byte_idx_d = byte_idx_q + 2'd1;
               if (byte_idx_q == 2'd3) begin
                  we_d       = 1'b1;
                  addr_d     = word_cnt_q;
                  wdata_d    = {rx_data, pack_q};
                  pack_d     = '0;
                  word_cnt_d = word_cnt_q + 1'b1;
                  if (word_cnt_q == ADDR_LAST) state_d = ST_DONE;
               end else begin
                  pack_d = pack_q | ({16'd0, rx_data} << {byte_idx_q, 3'b000});
               end
            end
         end
         ST_FLUSH: begin
            if (byte_idx_q != 2'd0) begin
               we_d    = 1'b1;
               addr_d  = word_cnt_q;
               wdata_d = {8'h00, pack_q};
            end
            state_d = ST_DONE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= ST_IDLE;
         start_q    <= 1'b0;
         word_cnt_q <= '0;
         byte_idx_q <= 2'd0;
         pack_q     <= '0;
         timer_q    <= '0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         ferr_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         start_q    <= start_load_i;
         word_cnt_q <= word_cnt_d;
         byte_idx_q <= byte_idx_d;
         pack_q     <= pack_d;
         timer_q    <= timer_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         ferr_q     <= ferr_d;
      end
   end

   assign imem_we_o    = we_q;
   assign imem_addr_o  = addr_q;
   assign imem_wdata_o = wdata_q;
   assign cpu_hold_o   = (state_q == ST_ARMED) || (state_q == ST_LOAD) || (state_q == ST_FLUSH);
   assign load_done_o  = (state_q == ST_DONE);
   assign frame_err_o  = ferr_q;

endmodule
`default_nettype wire

// File: tb/tb_imem_uart_loader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_imem_uart_loader : self-checking bench for the UART image loader
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_imem_uart_loader;

   localparam int CLK_HZ = 1_000_000;
   localparam int BAUD_R = 100_000;
   localparam int DIV    = 10;
   localparam int IBITS  = 4;
   localparam int AW     = 4;
   localparam int CAP    = 2 ** AW;

   logic          clk = 1'b0;
   logic          rst_n, rx, start;
   logic          imem_we, cpu_hold, load_done, frame_err;
   logic [AW-1:0] imem_addr;
   logic [31:0]   imem_wdata;

   always #5 clk = ~clk;

   imem_uart_loader #(
      .CLK_FREQ_HZ (CLK_HZ),
      .BAUD        (BAUD_R),
      .IDLE_BITS   (IBITS),
      .AW          (AW)
   ) dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .uart_rx_i    (rx),
      .start_load_i (start),
      .imem_we_o    (imem_we),
      .imem_addr_o  (imem_addr),
      .imem_wdata_o (imem_wdata),
      .cpu_hold_o   (cpu_hold),
      .load_done_o  (load_done),
      .frame_err_o  (frame_err)
   );

   int checks   = 0;
   int failures = 0;

   logic [AW-1:0] cap_addr[$];
   logic [31:0]   cap_data[$];
   logic [AW-1:0] exp_addr[$];
   logic [31:0]   exp_data[$];
   logic [7:0]    stim_bytes[$];
   bit            stim_bad[$];
   logic          we_prev = 1'b0;

   // Write monitor: records every strobe and checks it is one cycle wide.
   always @(negedge clk) begin
      if (imem_we) begin
         cap_addr.push_back(imem_addr);
         cap_data.push_back(imem_wdata);
      end
      if (we_prev) begin
         checks++;
         if (imem_we) begin
            failures++;
            $display("FAIL we_width: imem_we high %0d cycles in a row, required 1", 2);
         end
      end
      we_prev <= imem_we;
   end

   initial begin
      #900_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop, input int gap);
      rx = 1'b0;
      cyc(DIV);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         cyc(DIV);
      end
      rx = stop;
      cyc(DIV);
      rx = 1'b1;
      cyc(gap + (stop ? 0 : DIV));
   endtask

   task automatic pulse_start();
      start = 1'b0;
      cyc(2);
      start = 1'b1;
      cyc(2);
   endtask

   task automatic wait_done(input string name, input int budget);
      int n = 0;
      while (!load_done && n < budget) begin
         cyc(1);
         n++;
      end
      chk(name, {31'd0, load_done}, 32'd1);
   endtask

   task automatic check_writes(input string name);
      chk({name, "_nwr"}, cap_data.size(), exp_data.size());
      for (int i = 0; i < exp_data.size() && i < cap_data.size(); i++) begin
         chk($sformatf("%s_addr%0d", name, i), 32'(cap_addr[i]), 32'(exp_addr[i]));
         chk($sformatf("%s_data%0d", name, i), cap_data[i], exp_data[i]);
      end
   endtask

   // Reference: drop bad frames, pack survivors four per word little-endian,
   // zero-fill a trailing partial word, stop at memory capacity.
   task automatic model_load();
      logic [7:0] good[$];
      good = {};
      exp_addr.delete();
      exp_data.delete();
      foreach (stim_bytes[i]) if (!stim_bad[i]) good.push_back(stim_bytes[i]);
      for (int w = 0; w * 4 < good.size() && w < CAP; w++) begin
         logic [31:0] word;
         word = 32'd0;
         for (int k = 0; k < 4; k++)
            if (w * 4 + k < good.size()) word[8*k +: 8] = good[w*4+k];
         exp_addr.push_back(w[AW-1:0]);
         exp_data.push_back(word);
      end
   endtask

   task automatic run_load(input string name, input int mid_idx, input logic exp_ferr);
      int ngood = 0;
      cap_addr.delete();
      cap_data.delete();
      pulse_start();
      @(negedge clk);
      chk({name, "_arm_hold"}, {31'd0, cpu_hold},  32'd1);
      chk({name, "_arm_done"}, {31'd0, load_done}, 32'd0);
      chk({name, "_arm_ferr"}, {31'd0, frame_err}, 32'd0);
      cyc(1);
      foreach (stim_bytes[i]) begin
         if (i == mid_idx) pulse_start();
         send_byte(stim_bytes[i], !stim_bad[i], $urandom_range(3, 15));
         if (!stim_bad[i]) ngood++;
         if (!stim_bad[i] && ngood == 4 * CAP)
            chk({name, "_cap_done"}, {31'd0, load_done}, 32'd1);
      end
      if (ngood < 4 * CAP) begin
         cyc(20);
         chk({name, "_still_hold"}, {31'd0, cpu_hold},  32'd1);
         chk({name, "_not_done"},   {31'd0, load_done}, 32'd0);
      end
      wait_done({name, "_done"}, 200);
      cyc(5);
      chk({name, "_rel_hold"}, {31'd0, cpu_hold},  32'd0);
      chk({name, "_ferr"},     {31'd0, frame_err}, {31'd0, exp_ferr});
      check_writes(name);
   endtask

   typedef struct {
      int          n;
      logic [7:0]  b[12];
      logic [11:0] bad;
      int          nwr;
      logic [31:0] wd[3];
      logic        ferr;
   } vec_t;

   vec_t vecs[4];

   initial begin
      vecs[0].n = 8;  vecs[0].bad = 12'b0;   vecs[0].nwr = 2; vecs[0].ferr = 1'b0;
      vecs[0].b = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h0, 8'h0, 8'h0, 8'h0};
      vecs[0].wd = '{32'h12345678, 32'hDEADBEEF, 32'h0};
      vecs[1].n = 3;  vecs[1].bad = 12'b0;   vecs[1].nwr = 1; vecs[1].ferr = 1'b0;
      vecs[1].b = '{8'hAA, 8'hBB, 8'hCC, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0};
      vecs[1].wd = '{32'h00CCBBAA, 32'h0, 32'h0};
      vecs[2].n = 3;  vecs[2].bad = 12'b010; vecs[2].nwr = 1; vecs[2].ferr = 1'b1;
      vecs[2].b = '{8'h01, 8'h5A, 8'h02, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0};
      vecs[2].wd = '{32'h00000201, 32'h0, 32'h0};
      vecs[3].n = 5;  vecs[3].bad = 12'b0;   vecs[3].nwr = 2; vecs[3].ferr = 1'b0;
      vecs[3].b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0};
      vecs[3].wd = '{32'h44332211, 32'h00000055, 32'h0};

      rst_n = 1'b0;
      rx    = 1'b1;
      start = 1'b0;
      cyc(5);
      @(negedge clk);
      chk("rst_we",    {31'd0, imem_we},   32'd0);
      chk("rst_hold",  {31'd0, cpu_hold},  32'd0);
      chk("rst_done",  {31'd0, load_done}, 32'd0);
      chk("rst_ferr",  {31'd0, frame_err}, 32'd0);
      cyc(1);
      rst_n = 1'b1;
      cyc(5);

      // Reset in the middle of a frame during a load.
      pulse_start();
      rx = 1'b0;
      cyc(DIV);
      rx = 1'b1;
      cyc(3 * DIV);
      rst_n = 1'b0;
      start = 1'b0;
      cyc(2);
      @(negedge clk);
      chk("mid_rst_we",    {31'd0, imem_we},   32'd0);
      chk("mid_rst_addr",  32'(imem_addr),     32'd0);
      chk("mid_rst_wdata", imem_wdata,         32'd0);
      chk("mid_rst_hold",  {31'd0, cpu_hold},  32'd0);
      chk("mid_rst_done",  {31'd0, load_done}, 32'd0);
      chk("mid_rst_ferr",  {31'd0, frame_err}, 32'd0);
      cyc(1);
      rx = 1'b1;
      cyc(3);
      rst_n = 1'b1;
      cyc(5);
      cap_addr.delete();
      cap_data.delete();
      for (int i = 0; i < 4; i++) send_byte(8'(8'h11 * (i + 1)), 1'b1, 5);
      cyc(60);
      chk("idle_no_we",   cap_data.size(),     32'd0);
      chk("idle_no_hold", {31'd0, cpu_hold},  32'd0);
      chk("idle_no_done", {31'd0, load_done}, 32'd0);

      // Table-driven loads.
      for (int v = 0; v < 4; v++) begin
         stim_bytes.delete();
         stim_bad.delete();
         exp_addr.delete();
         exp_data.delete();
         for (int i = 0; i < vecs[v].n; i++) begin
            stim_bytes.push_back(vecs[v].b[i]);
            stim_bad.push_back(vecs[v].bad[i]);
         end
         for (int w = 0; w < vecs[v].nwr; w++) begin
            exp_addr.push_back(w[AW-1:0]);
            exp_data.push_back(vecs[v].wd[w]);
         end
         run_load($sformatf("vec%0d", v), -1, vecs[v].ferr);
      end

      // Line glitches: 3 cycles low is noise, 20 cycles low reads as byte FE.
      cap_addr.delete();
      cap_data.delete();
      pulse_start();
      rx = 1'b0;
      cyc(3);
      rx = 1'b1;
      cyc(60);
      rx = 1'b0;
      cyc(20);
      rx = 1'b1;
      cyc(90);
      send_byte(8'h11, 1'b1, 5);
      send_byte(8'h22, 1'b1, 5);
      send_byte(8'h33, 1'b1, 5);
      wait_done("glitch_done", 200);
      exp_addr.delete();
      exp_data.delete();
      exp_addr.push_back('0);
      exp_data.push_back(32'h332211FE);
      check_writes("glitch");

      // Capacity overflow with an ignored start_load edge mid-load.
      stim_bytes.delete();
      stim_bad.delete();
      for (int i = 0; i < 4 * CAP + 4; i++) begin
         stim_bytes.push_back(8'($urandom));
         stim_bad.push_back(1'b0);
      end
      model_load();
      run_load("cap", 10, 1'b0);

      // Randomized loads against the reference model.
      for (int r = 0; r < 6; r++) begin
         int n;
         bit anybad;
         n = $urandom_range(1, 20);
         anybad = 1'b0;
         stim_bytes.delete();
         stim_bad.delete();
         for (int i = 0; i < n; i++) begin
            bit b;
            b = (i != n - 1) && ($urandom_range(0, 7) == 0);
            anybad |= b;
            stim_bytes.push_back(8'($urandom));
            stim_bad.push_back(b);
         end
         model_load();
         run_load($sformatf("rnd%0d", r), -1, anybad);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
